// File: rtl/sobel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sobel_pkg                                                       |
// | Purpose  : Shared definitions for the Sobel front end: pixel width, 3x3    |
// |            window element indices and the window generator state codes.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sobel_pkg;

  localparam int PIX_W = 8;

  // Window element index k = 3*r + c (r = 0 top row, c = 0 left column).
  localparam int W_TL = 0;
  localparam int W_TC = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MC = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BC = 7;
  localparam int W_BR = 8;

  // Window generator state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sobel_line_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sobel_line_delay                                                |
// | Purpose  : 2**DEPTH_E deep, WIDTH wide delay line advanced by shift_en.    |
// |            dout is the sample written 2**DEPTH_E shifts ago; it is valid   |
// |            during the cycle in which the next shift takes place.           |
// | Ports    : clk, reset (async, active-high), shift_en, din[WIDTH], dout     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sobel_line_delay #(
  parameter int DEPTH_E = 9,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** DEPTH_E;

  // Circular buffer: the slot under the pointer is read as the oldest sample
  // and overwritten with the newest one on the same shift. Contents are not
  // reset; downstream padding masks stale data.
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_E-1:0] ptr_q;
  logic [DEPTH_E-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (shift_en) begin
      ptr_d = ptr_q + DEPTH_E'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_q[ptr_q] <= din;
    end
  end

  assign dout = mem_q[ptr_q];

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sobel_window_gen                                                |
// | Purpose  : Streaming zero-padded 3x3 window generator feeding the Sobel    |
// |            gradient stage. One window (with centre row/col) per pixel.     |
// | Ports    : clk, reset (async, active-high)                                 |
// |            s_valid/s_ready/s_data/s_sof      : raster pixel input          |
// |            m_valid/m_ready/m_window/m_row/m_col/m_eof : window output      |
// |            frame_err                         : sticky misplaced-sof flag   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sobel_window_gen #(
  parameter int IMG_W_E = 9,
  parameter int IMG_H_E = 9,
  parameter int IMG_W   = 2 ** IMG_W_E,
  parameter int IMG_H   = 2 ** IMG_H_E,
  parameter int PIX_W   = sobel_pkg::PIX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PIX_W-1:0]     s_data,
  input  logic                 s_sof,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [9*PIX_W-1:0]   m_window,
  output logic [IMG_H_E-1:0]   m_row,
  output logic [IMG_W_E-1:0]   m_col,
  output logic                 m_eof,
  output logic                 frame_err
);

  import sobel_pkg::*;

  localparam logic [IMG_W_E-1:0] COL_LAST = IMG_W_E'(IMG_W - 1);
  localparam logic [IMG_H_E-1:0] ROW_LAST = IMG_H_E'(IMG_H - 1);

  logic [1:0]               state_q,     state_d;
  logic [IMG_W_E-1:0]       in_col_q,    in_col_d;
  logic [IMG_H_E-1:0]       in_row_q,    in_row_d;
  logic [IMG_W_E-1:0]       cen_col_q,   cen_col_d;
  logic [IMG_H_E-1:0]       cen_row_q,   cen_row_d;
  logic                     m_valid_q,   m_valid_d;
  logic [9*PIX_W-1:0]       m_window_q,  m_window_d;
  logic [IMG_H_E-1:0]       m_row_q,     m_row_d;
  logic [IMG_W_E-1:0]       m_col_q,     m_col_d;
  logic                     m_eof_q,     m_eof_d;
  logic                     frame_err_q, frame_err_d;
  // Two older columns per window row: [row][0] = leftmost, [row][1] = middle.
  logic [2:0][1:0][PIX_W-1:0] tap_q, tap_d;

  logic                     out_free;
  logic                     accept;
  logic                     shift_en;
  logic                     produce;
  logic                     in_adv;
  logic                     restart;
  logic [PIX_W-1:0]         shift_data;
  logic [PIX_W-1:0]         ld1_out;
  logic [PIX_W-1:0]         ld2_out;
  logic [2:0][PIX_W-1:0]    new_col;
  logic [2:0][2:0][PIX_W-1:0] cur;
  logic [2:0]               row_ok;
  logic [2:0]               col_ok;
  logic [9*PIX_W-1:0]       win;

  assign out_free = !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;

  always_comb begin
    s_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE, ST_FILL: s_ready = 1'b1;
        ST_RUN:           s_ready = out_free;
        default:          s_ready = 1'b0;
      endcase
    end
  end

  // During FLUSH the pipeline is advanced with zero pixels; every window that
  // would see them has its bottom row or right column masked anyway.
  assign shift_data = (state_q == ST_FLUSH) ? '0 : s_data;

  sobel_line_delay #(.DEPTH_E(IMG_W_E), .WIDTH(PIX_W)) u_ld1 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (shift_data),
    .dout     (ld1_out)
  );

  sobel_line_delay #(.DEPTH_E(IMG_W_E), .WIDTH(PIX_W)) u_ld2 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (ld1_out),
    .dout     (ld2_out)
  );

  // The incoming pixel is always the bottom-right element of the window being
  // produced, so the newest column comes straight from the input and the two
  // line delay outputs.
  assign new_col[0] = ld2_out;
  assign new_col[1] = ld1_out;
  assign new_col[2] = shift_data;

  always_comb begin
    tap_d = tap_q;
    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        tap_d[r][0] = tap_q[r][1];
        tap_d[r][1] = new_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    tap_q <= tap_d;
  end

  always_comb begin
    row_ok = {cen_row_q != ROW_LAST, 1'b1, cen_row_q != '0};
    col_ok = {cen_col_q != COL_LAST, 1'b1, cen_col_q != '0};
    win    = '0;
    for (int r = 0; r < 3; r++) begin
      cur[r][0] = tap_q[r][0];
      cur[r][1] = tap_q[r][1];
      cur[r][2] = new_col[r];
      for (int c = 0; c < 3; c++) begin
        if (row_ok[r] && col_ok[c]) begin
          win[(3*r + c)*PIX_W +: PIX_W] = cur[r][c];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    cen_col_d   = cen_col_q;
    cen_row_d   = cen_row_q;
    m_valid_d   = m_valid_q;
    m_window_d  = m_window_q;
    m_row_d     = m_row_q;
    m_col_d     = m_col_q;
    m_eof_d     = m_eof_q;
    frame_err_d = frame_err_q;
    shift_en    = 1'b0;
    produce     = 1'b0;
    in_adv      = 1'b0;
    restart     = 1'b0;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && s_sof) begin
          shift_en = 1'b1;
          restart  = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          shift_en = 1'b1;
          if (s_sof) begin
            frame_err_d = 1'b1;
            restart     = 1'b1;
          end else begin
            in_adv = 1'b1;
            // Index IMG_W (row 1, col 0) completes the priming of the taps.
            if (in_row_q == IMG_H_E'(1) && in_col_q == '0) begin
              state_d = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          shift_en = 1'b1;
          if (s_sof) begin
            frame_err_d = 1'b1;
            restart     = 1'b1;
            m_valid_d   = 1'b0;
            state_d     = ST_FILL;
          end else begin
            produce = 1'b1;
            in_adv  = 1'b1;
            if (in_row_q == ROW_LAST && in_col_q == COL_LAST) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (m_valid_q && m_eof_q) begin
          if (m_ready) begin
            state_d = ST_IDLE;
          end
        end else if (out_free) begin
          shift_en = 1'b1;
          produce  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The sof pixel itself is index 0, so the next expected index is 1.
    if (restart) begin
      in_col_d  = IMG_W_E'(1);
      in_row_d  = '0;
      cen_col_d = '0;
      cen_row_d = '0;
    end else if (in_adv) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = in_row_q + IMG_H_E'(1);
      end else begin
        in_col_d = in_col_q + IMG_W_E'(1);
      end
    end

    if (produce) begin
      m_valid_d  = 1'b1;
      m_window_d = win;
      m_row_d    = cen_row_q;
      m_col_d    = cen_col_q;
      m_eof_d    = (cen_row_q == ROW_LAST) && (cen_col_q == COL_LAST);
      if (cen_col_q == COL_LAST) begin
        cen_col_d = '0;
        cen_row_d = cen_row_q + IMG_H_E'(1);
      end else begin
        cen_col_d = cen_col_q + IMG_W_E'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_col_q    <= '0;
      in_row_q    <= '0;
      cen_col_q   <= '0;
      cen_row_q   <= '0;
      m_valid_q   <= 1'b0;
      m_window_q  <= '0;
      m_row_q     <= '0;
      m_col_q     <= '0;
      m_eof_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      cen_col_q   <= cen_col_d;
      cen_row_q   <= cen_row_d;
      m_valid_q   <= m_valid_d;
      m_window_q  <= m_window_d;
      m_row_q     <= m_row_d;
      m_col_q     <= m_col_d;
      m_eof_q     <= m_eof_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_window  = m_window_q;
  assign m_row     = m_row_q;
  assign m_col     = m_col_q;
  assign m_eof     = m_eof_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
